// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Latches the decode control word, operands and destination register. It finds
// load-use hazards against the instruction in execute and turns them into a
// bubble plus a one-cycle fetch/decode freeze. It also applies branch flushes
// and memory-wait holds, and keeps a saturating debug count of the bubbles it
// has inserted.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          synchronous active-high reset
//   id_ctrl      decode control word ([7] wre, [6] mem write, [5:4] wb sel, [3:0] aluOp)
//   id_rs1/2     decode source register addresses
//   id_rs1/2_used  source operand is actually read
//   id_rd        decode destination register
//   id_a/b/imm   decode operand data and extended immediate
//   flush        branch taken in execute, discard the decode instruction
//   mem_busy     data memory not ready, freeze the whole pipeline
//   ex_*         registered control, destination and operands for execute
//   ex_valid     ex_ctrl holds a real instruction (0 for bubble/reset)
//   stall        freeze PC and IF/ID this cycle (combinational)
//   bubble_cnt   saturating count of hazard bubbles
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       id_ctrl,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic              mem_busy,
    output logic [15:0]       ex_ctrl,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_valid,
    output logic              stall,
    output logic [15:0]       bubble_cnt
);

    logic [15:0]       ex_ctrl_q, ex_ctrl_d;
    logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic              ex_valid_q, ex_valid_d;
    logic [15:0]       bubble_cnt_q, bubble_cnt_d;

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    // A load is wre with memory writeback select and aluOp 1; stores are excluded by wre.
    assign ex_is_load = ex_ctrl_q[7] & (ex_ctrl_q[5:4] == 2'b00) & (ex_ctrl_q[3:0] == 4'b0001);
    assign rs1_hit    = id_rs1_used & (id_rs1 == ex_rd_q);
    assign rs2_hit    = id_rs2_used & (id_rs2 == ex_rd_q);
    assign hazard     = ex_is_load & ex_valid_q & (rs1_hit | rs2_hit);

    // A flushed decode instruction is wrong-path, so its hazard must not freeze fetch.
    assign stall = mem_busy | (hazard & ~flush);

    always_comb begin
        ex_ctrl_d    = ex_ctrl_q;
        ex_rd_d      = ex_rd_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_imm_d     = ex_imm_q;
        ex_valid_d   = ex_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (mem_busy) begin
            // hold everything, including a coincident flush
        end else if (flush || hazard) begin
            ex_ctrl_d  = '0;
            ex_rd_d    = '0;
            ex_a_d     = '0;
            ex_b_d     = '0;
            ex_imm_d   = '0;
            ex_valid_d = 1'b0;
            if (!flush && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end else begin
            ex_ctrl_d  = id_ctrl;
            ex_rd_d    = id_rd;
            ex_a_d     = id_a;
            ex_b_d     = id_b;
            ex_imm_d   = id_imm;
            ex_valid_d = (id_ctrl != 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q    <= '0;
            ex_rd_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_valid_q   <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rd_q      <= ex_rd_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_imm_q     <= ex_imm_d;
            ex_valid_q   <= ex_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rd      = ex_rd_q;
    assign ex_a       = ex_a_q;
    assign ex_b       = ex_b_q;
    assign ex_imm     = ex_imm_q;
    assign ex_valid   = ex_valid_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a behavioural model.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   id_ctrl;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used;
    logic [DW-1:0] id_a, id_b, id_imm;
    logic          flush, mem_busy;
    logic [15:0]   ex_ctrl;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic          ex_valid, stall;
    logic [15:0]   bubble_cnt;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_ctrl     (id_ctrl),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_a        (id_a),
        .id_b        (id_b),
        .id_imm      (id_imm),
        .flush       (flush),
        .mem_busy    (mem_busy),
        .ex_ctrl     (ex_ctrl),
        .ex_rd       (ex_rd),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_imm      (ex_imm),
        .ex_valid    (ex_valid),
        .stall       (stall),
        .bubble_cnt  (bubble_cnt)
    );

    // ---------------- behavioural model ----------------
    logic [15:0]   m_ctrl;
    logic [RW-1:0] m_rd;
    logic [DW-1:0] m_a, m_b, m_imm;
    logic          m_valid;
    logic [15:0]   m_cnt;

    function automatic bit model_hazard();
        bit is_load;
        bit reads_rd;
        is_load  = (m_ctrl[7] == 1'b1) && (m_ctrl[5:4] == 2'b00) && (m_ctrl[3:0] == 4'd1);
        reads_rd = (id_rs1_used && id_rs1 == m_rd) || (id_rs2_used && id_rs2 == m_rd);
        return is_load && m_valid && reads_rd;
    endfunction

    function automatic bit model_stall();
        return mem_busy || (model_hazard() && !flush);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ctrl <= 0; m_rd <= 0; m_a <= 0; m_b <= 0; m_imm <= 0;
            m_valid <= 0; m_cnt <= 0;
        end else if (mem_busy) begin
            // frozen
        end else if (flush || model_hazard()) begin
            m_ctrl <= 0; m_rd <= 0; m_a <= 0; m_b <= 0; m_imm <= 0;
            m_valid <= 0;
            if (!flush && m_cnt < 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        end else begin
            m_ctrl <= id_ctrl; m_rd <= id_rd; m_a <= id_a; m_b <= id_b; m_imm <= id_imm;
            m_valid <= (id_ctrl != 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
            chk("ex_rd", 64'(ex_rd), 64'(m_rd));
            chk("ex_a", 64'(ex_a), 64'(m_a));
            chk("ex_b", 64'(ex_b), 64'(m_b));
            chk("ex_imm", 64'(ex_imm), 64'(m_imm));
            chk("ex_valid", 64'(ex_valid), 64'(m_valid));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
            chk("stall", 64'(stall), 64'(model_stall()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] c, input int rd, input int rs1, input bit u1,
                         input int rs2, input bit u2, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] imm);
        id_ctrl = c; id_rd = RW'(rd);
        id_rs1 = RW'(rs1); id_rs1_used = u1;
        id_rs2 = RW'(rs2); id_rs2_used = u2;
        id_a = a; id_b = b; id_imm = imm;
    endtask

    task automatic drive_random();
        case ($urandom_range(0, 4))
            0: id_ctrl = 16'h0081;
            1: id_ctrl = 16'h0091;
            2: id_ctrl = 16'h0041;
            3: id_ctrl = 16'h0000;
            default: id_ctrl = {8'h00, 8'($urandom)};
        endcase
        id_rd = RW'($urandom_range(0, 3));
        id_rs1 = RW'($urandom_range(0, 3));
        id_rs2 = RW'($urandom_range(0, 3));
        id_rs1_used = 1'($urandom);
        id_rs2_used = 1'($urandom);
        id_a = $urandom; id_b = $urandom; id_imm = $urandom;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_busy = 1'b0;
        drive_random();
        step();
        check_en = 1'b1;
        drive_random();
        step();
        chk("reset ex_ctrl", 64'(ex_ctrl), 64'h0);
        chk("reset ex_valid", 64'(ex_valid), 64'h0);
        chk("reset bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("reset stall", 64'(stall), 64'h0);
        rst = 1'b0;

        // load-use: ldr r3 then add reading r3
        drive(16'h0081, 3, 0, 0, 0, 0, 32'h100, 0, 4);
        step();
        chk("ldr in ex", 64'(ex_ctrl), 64'h0081);
        chk("ldr valid", 64'(ex_valid), 64'h1);
        drive(16'h0091, 6, 3, 1, 1, 0, 32'h11, 32'h22, 32'h33);
        #1 chk("load-use stall", 64'(stall), 64'h1);
        step();
        chk("bubble ctrl", 64'(ex_ctrl), 64'h0);
        chk("bubble valid", 64'(ex_valid), 64'h0);
        chk("bubble cnt", 64'(bubble_cnt), 64'h1);
        chk("stall released", 64'(stall), 64'h0);
        step();
        chk("add after bubble", 64'(ex_ctrl), 64'h0091);
        chk("add rd", 64'(ex_rd), 64'h6);

        // no false hazard: unused operand, then different register
        drive(16'h0081, 3, 0, 0, 0, 0, 1, 2, 3);
        step();
        drive(16'h0091, 6, 3, 0, 0, 0, 4, 5, 6);
        #1 chk("unused rs1 stall", 64'(stall), 64'h0);
        step();
        chk("unused rs1 add", 64'(ex_ctrl), 64'h0091);
        drive(16'h0081, 3, 0, 0, 0, 0, 1, 2, 3);
        step();
        drive(16'h0091, 6, 4, 1, 0, 0, 4, 5, 6);
        #1 chk("other reg stall", 64'(stall), 64'h0);
        step();
        chk("other reg add", 64'(ex_ctrl), 64'h0091);

        // flush over hazard
        drive(16'h0081, 5, 0, 0, 0, 0, 1, 2, 3);
        step();
        drive(16'h0091, 6, 0, 0, 5, 1, 4, 5, 6);
        flush = 1'b1;
        #1 chk("flush stall", 64'(stall), 64'h0);
        step();
        flush = 1'b0;
        chk("flush ctrl", 64'(ex_ctrl), 64'h0);
        chk("flush valid", 64'(ex_valid), 64'h0);
        chk("flush cnt", 64'(bubble_cnt), 64'h1);

        // memory hold
        drive(16'h0091, 7, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 2);
        step();
        chk("hold load", 64'(ex_a), 64'hDEAD_BEEF);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(16'h0041, i, 0, 0, 0, 0, 32'(100 + i), 9, 9);
            #1 chk("hold stall", 64'(stall), 64'h1);
            step();
            chk("hold ex_a", 64'(ex_a), 64'hDEAD_BEEF);
            chk("hold ex_ctrl", 64'(ex_ctrl), 64'h0091);
        end
        mem_busy = 1'b0;
        drive(16'h0041, 9, 0, 0, 0, 0, 32'h1234_5678, 9, 9);
        step();
        chk("release ex_a", 64'(ex_a), 64'h1234_5678);
        chk("release ex_ctrl", 64'(ex_ctrl), 64'h0041);
        mem_busy = 1'b1; flush = 1'b1;
        drive(16'h0091, 1, 0, 0, 0, 0, 5, 5, 5);
        step();
        chk("busy beats flush", 64'(ex_ctrl), 64'h0041);
        flush = 1'b0;

        // saturation: preload the counter near the top while the pipe is frozen
        step();
        force dut.bubble_cnt_q = 16'hFFF0;
        m_cnt = 16'hFFF0;
        step();
        release dut.bubble_cnt_q;
        step();
        mem_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(16'h0081, 2, 0, 0, 0, 0, 1, 1, 1);
            step();
            drive(16'h0091, 3, 2, 1, 0, 0, 1, 1, 1);
            step();
            if (i == 13) chk("cnt near top", 64'(bubble_cnt), 64'hFFFE);
        end
        chk("cnt saturated", 64'(bubble_cnt), 64'hFFFF);

        // randomized run
        for (int n = 0; n < 4000; n++) begin
            drive_random();
            rst = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            mem_busy = ($urandom_range(0, 99) < 15);
            step();
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute. It latches the 16-bit control word, operand data and destination register produced in decode. It detects load-use hazards against the instruction currently in execute, inserts a bubble (all-zero control word) when a hazard is found, and requests a one-cycle freeze of fetch/decode. It also applies branch flushes and memory-wait holds, and keeps a saturating count of inserted bubbles for debug.

## Interface
Parameters:
- DATA_W, 32, width of operand and immediate data
- REG_W, 4, width of register addresses

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst  in  1  synchronous, active-high reset
- id_ctrl  in  16  decode control word: [15:8] zero, [7] wre, [6] write_memory_enable, [5:4] select_writeback_data_mux, [3:0] aluOp
- id_rs1, id_rs2  in  REG_W  source register addresses of decode instruction
- id_rs1_used, id_rs2_used  in  1  source operand actually read
- id_rd  in  REG_W  destination register
- id_a, id_b  in  DATA_W  register-file read data
- id_imm  in  DATA_W  extended immediate
- flush  in  1  branch taken in execute; discard decode instruction
- mem_busy  in  1  data memory not ready; freeze whole pipeline
- ex_ctrl  out  16  registered control word to execute
- ex_rd  out  REG_W  registered destination
- ex_a, ex_b, ex_imm  out  DATA_W  registered operands
- ex_valid  out  1  1 when ex_ctrl came from a real instruction, 0 for bubble/reset
- stall  out  1  freeze PC and IF/ID register this cycle (combinational)
- bubble_cnt  out  16  saturating count of hazard bubbles inserted

## Operation
- ex_is_load = ex_ctrl[7] & (ex_ctrl[5:4] == 2'b00) & (ex_ctrl[3:0] == 4'b0001).
- hazard = ex_is_load & ex_valid & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)). Register 0 has no special handling and compares like any other register.
- Per-edge update, in priority order (first match wins):
  1. rst: all registered outputs = 0; ex_valid = 0; bubble_cnt = 0.
  2. mem_busy: every register holds; bubble_cnt holds.
  3. flush: ex_ctrl = 0; ex_valid = 0; ex_rd/ex_a/ex_b/ex_imm = 0; bubble_cnt unchanged.
  4. hazard: same bubble as flush; bubble_cnt += 1, saturating at 16'hFFFF.
  5. Otherwise: load all id_* inputs; ex_valid = 1 when id_ctrl != 0, else 0.
- stall = mem_busy | (hazard & ~flush).
  - A flush suppresses the hazard stall because the decode instruction is wrong-path.
  - During mem_busy, stall is 1 whatever the hazard state.
- A hazard lasts exactly one cycle. The bubble clears ex_is_load, so the next cycle's decode instruction (held by stall) advances normally.
- Store (ctrl[6]) and add (sel 01) in execute never cause a hazard.

## Timing
- Latency: decode to execute is 1 cycle.
- Outputs ex_*, ex_valid and bubble_cnt are registered. stall depends combinationally on id_rs*, id_rs*_used, flush, mem_busy and the current ex_* registers.
- Reset values: ex_ctrl 16'h0000, ex_rd 0, ex_a/ex_b/ex_imm 0, ex_valid 0, bubble_cnt 0. In the reset cycle stall follows mem_busy, since ex_valid is 0 and no hazard can exist.
- rst mid-stall or mid-hold: reset wins on that edge. The next edge after rst deasserts loads decode normally.
- mem_busy and flush asserted together: hold wins. The flush must be re-presented by execute, which is also frozen.
- Back-to-back loads where the second depends on the first: one bubble between them, then normal flow.

## Test plan
- Reset: hold rst 2 cycles with random id_* inputs. Required: ex_ctrl=0, ex_valid=0, bubble_cnt=0, stall=0.
- Load-use: ldr rd=3 (id_ctrl=16'h0081), then add with rs1=3 and rs1_used=1. Required: stall=1 for one cycle, ex_ctrl=0 and ex_valid=0 the following cycle, bubble_cnt=1, then add (16'h0091) reaches ex_ctrl.
- No false hazard: ldr rd=3, then add with rs1=3 but rs1_used=0, or rs1=4. Required: stall=0, and add appears in execute the next cycle.
- Flush over hazard: ldr rd=5 in execute, decode reads r5, flush=1. Required: stall=0, bubble inserted, bubble_cnt unchanged.
- Memory hold: load ex state (ctrl 16'h0091, ex_a=32'hDEAD_BEEF), then assert mem_busy 3 cycles with changing inputs. Required: ex_* constant, stall=1 throughout, and the new input latched on the first edge after release.
- Counter saturation: force 65 537 hazards. Required: bubble_cnt stops at 16'hFFFF.
